// File: rtl/isa_pkg.sv
// Shared opcode encoding and FSM types for the instruction sequencer.
package isa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_MEM_WAIT,
    ST_WB,
    ST_HALTED
  } state_e;

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_ALU = 2'b01,
    OP_MEM = 2'b10,
    OP_SYS = 2'b11
  } op_class_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_SHL, ALU_SHR
  } alu_op_e;

  localparam logic [7:0] OPC_NOP  = 8'hC0;
  localparam logic [7:0] OPC_HALT = 8'hFF;

  localparam int CLS_LSB   = 6;
  localparam int RA_LSB    = 3;
  localparam int RB_LSB    = 0;
  localparam int STORE_BIT = 5;
  localparam int FIELD_W   = 3;

  function automatic logic reg_oob(input logic [FIELD_W-1:0] idx, input int nregs);
    return int'(idx) >= nregs;
  endfunction

endpackage

// File: rtl/op_field_decode.sv
// Combinational split of an 8-bit opcode into its fields plus the illegal flag.
module op_field_decode
  import isa_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 4
) (
  input  logic [7:0]         i_op,
  output op_class_e          o_cls,
  output logic [FIELD_W-1:0] o_ra,
  output logic [FIELD_W-1:0] o_rb,
  output logic               o_store,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_halt,
  output logic               o_illegal
);

  always_comb begin
    o_cls     = op_class_e'(i_op[CLS_LSB +: 2]);
    o_ra      = i_op[RA_LSB +: FIELD_W];
    o_rb      = i_op[RB_LSB +: FIELD_W];
    o_store   = i_op[STORE_BIT];
    o_addr    = i_op[ADDR_W-1:0];
    o_halt    = (i_op == OPC_HALT);
    o_illegal = 1'b0;
    unique case (o_cls)
      OP_MOV:  o_illegal = reg_oob(o_ra, NUM_REGS) || reg_oob(o_rb, NUM_REGS);
      OP_ALU:  o_illegal = reg_oob(o_rb, NUM_REGS);
      OP_MEM:  o_illegal = 1'b0;
      OP_SYS:  o_illegal = (i_op != OPC_NOP) && (i_op != OPC_HALT);
      default: o_illegal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle opcode sequencer: latch, decode, execute, memory handshake, write-back.
module instr_sequencer
  import isa_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 3,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [7:0]          instr,
  output logic                instr_ready,
  output logic [2:0]          alu_sel,
  output logic                acc_sel,
  output logic [SEL_W-1:0]    alu_b_sel,
  output logic [SEL_W-1:0]    source_reg_sel,
  output logic [NUM_REGS-1:0] destination_reg_flag,
  output logic                mem_req,
  output logic                write,
  output logic [ADDR_W-1:0]   address,
  input  logic                mem_ack,
  output logic                busy,
  output logic                halted,
  input  logic                resume,
  output logic                illegal
);

  state_e              r_state;
  logic [7:0]          r_opcode;

  op_class_e           w_cls;
  logic [FIELD_W-1:0]  w_ra, w_rb;
  logic                w_store, w_halt, w_ill;
  logic [ADDR_W-1:0]   w_addr;

  op_class_e           r_f_cls;
  logic [FIELD_W-1:0]  r_f_ra, r_f_rb;
  logic                r_f_store, r_f_halt, r_f_ill;
  logic [ADDR_W-1:0]   r_f_addr;

  logic                r_ready, r_acc, r_mem_req, r_write, r_busy, r_halted, r_illegal;
  logic [2:0]          r_alu_sel;
  logic [SEL_W-1:0]    r_alu_b, r_src_sel;
  logic [NUM_REGS-1:0] r_dest;
  logic [ADDR_W-1:0]   r_addr;

  op_field_decode #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_dec (
    .i_op      (r_opcode),
    .o_cls     (w_cls),
    .o_ra      (w_ra),
    .o_rb      (w_rb),
    .o_store   (w_store),
    .o_addr    (w_addr),
    .o_halt    (w_halt),
    .o_illegal (w_ill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_opcode  <= '0;
      r_f_cls   <= OP_MOV;
      r_f_ra    <= '0;
      r_f_rb    <= '0;
      r_f_store <= 1'b0;
      r_f_halt  <= 1'b0;
      r_f_ill   <= 1'b0;
      r_f_addr  <= '0;
      r_ready   <= 1'b0;
      r_acc     <= 1'b0;
      r_mem_req <= 1'b0;
      r_write   <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_alu_sel <= '0;
      r_alu_b   <= '0;
      r_src_sel <= '0;
      r_dest    <= '0;
      r_addr    <= '0;
    end else begin
      // Strobe outputs are single-cycle: cleared unless a state re-asserts them.
      r_dest    <= '0;
      r_illegal <= 1'b0;
      r_acc     <= 1'b0;
      r_alu_sel <= '0;
      r_alu_b   <= '0;
      r_src_sel <= '0;
      unique case (r_state)
        ST_IDLE: begin
          if (instr_valid && r_ready) begin
            r_opcode <= instr;
            r_state  <= ST_DECODE;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
          end else begin
            r_ready  <= 1'b1;
          end
        end
        ST_DECODE: begin
          r_f_cls   <= w_cls;
          r_f_ra    <= w_ra;
          r_f_rb    <= w_rb;
          r_f_store <= w_store;
          r_f_halt  <= w_halt;
          r_f_ill   <= w_ill;
          r_f_addr  <= w_addr;
          r_state   <= ST_EXEC;
        end
        ST_EXEC: begin
          if (r_f_ill) begin
            r_illegal <= 1'b1;
            r_state   <= ST_IDLE;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            unique case (r_f_cls)
              OP_MOV: begin
                r_src_sel <= SEL_W'(r_f_rb);
                r_dest    <= NUM_REGS'(1) << r_f_ra;
                r_state   <= ST_IDLE;
                r_ready   <= 1'b1;
                r_busy    <= 1'b0;
              end
              OP_ALU: begin
                r_alu_sel <= r_f_ra;
                r_alu_b   <= SEL_W'(r_f_rb);
                r_acc     <= 1'b1;
                r_dest    <= NUM_REGS'(1);
                r_state   <= ST_IDLE;
                r_ready   <= 1'b1;
                r_busy    <= 1'b0;
              end
              OP_MEM: begin
                r_mem_req <= 1'b1;
                r_write   <= r_f_store;
                r_addr    <= r_f_addr;
                r_state   <= ST_MEM_WAIT;
              end
              default: begin
                r_busy <= 1'b0;
                if (r_f_halt) begin
                  r_halted <= 1'b1;
                  r_state  <= ST_HALTED;
                end else begin
                  r_state  <= ST_IDLE;
                  r_ready  <= 1'b1;
                end
              end
            endcase
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            if (r_write) begin
              r_state <= ST_IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_WB;
            end
          end
        end
        ST_WB: begin
          r_dest  <= NUM_REGS'(1);
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        ST_HALTED: begin
          if (resume) begin
            r_halted <= 1'b0;
            r_state  <= ST_IDLE;
            r_ready  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready          = r_ready;
  assign alu_sel              = r_alu_sel;
  assign acc_sel              = r_acc;
  assign alu_b_sel            = r_alu_b;
  assign source_reg_sel       = r_src_sel;
  assign destination_reg_flag = r_dest;
  assign mem_req              = r_mem_req;
  assign write                = r_write;
  assign address              = r_addr;
  assign busy                 = r_busy;
  assign halted               = r_halted;
  assign illegal              = r_illegal;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed plus randomized opcode stream checked against a per-opcode behavioural model.
module tb_instr_sequencer;
  localparam int NR = 4, SW = 3, AW = 4;
  localparam int K_MOV = 0, K_ALU = 1, K_LOAD = 2, K_STORE = 3, K_NOP = 4, K_ILL = 5, K_HALT = 6;

  logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, mem_ack = 1'b0, resume = 1'b0;
  logic [7:0] instr = 8'h00;
  logic instr_ready, acc_sel, mem_req, write, busy, halted, illegal;
  logic [2:0] alu_sel;
  logic [SW-1:0] alu_b_sel, source_reg_sel;
  logic [NR-1:0] destination_reg_flag;
  logic [AW-1:0] address;

  int n_vec = 0, n_err = 0;

  instr_sequencer #(.NUM_REGS(NR), .SEL_W(SW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_sel(alu_sel), .acc_sel(acc_sel),
    .alu_b_sel(alu_b_sel), .source_reg_sel(source_reg_sel),
    .destination_reg_flag(destination_reg_flag), .mem_req(mem_req),
    .write(write), .address(address), .mem_ack(mem_ack), .busy(busy),
    .halted(halted), .resume(resume), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [2:0] src;
    logic [3:0] dflag;
    logic [2:0] alu;
    logic [2:0] b;
    logic [3:0] addr;
  } exp_t;

  function automatic exp_t model(input logic [7:0] op);
    exp_t e;
    int cls = int'(op) / 64;
    int hi  = (int'(op) / 8) % 8;
    int lo  = int'(op) % 8;
    e.kind = K_NOP; e.src = 3'(lo); e.dflag = 4'(1 << hi); e.alu = 3'(hi); e.b = 3'(lo);
    e.addr = 4'(int'(op) % 16);
    case (cls)
      0: e.kind = (hi < NR && lo < NR) ? K_MOV : K_ILL;
      1: e.kind = (lo < NR) ? K_ALU : K_ILL;
      2: e.kind = ((int'(op) / 32) % 2 == 1) ? K_STORE : K_LOAD;
      default: e.kind = (op == 8'hC0) ? K_NOP : (op == 8'hFF) ? K_HALT : K_ILL;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_instr(input logic [7:0] op, input int d, input bit early);
    exp_t e = model(op);
    int w = 0;
    while (!instr_ready && w < 20) begin @(negedge clk); w++; end
    chk("ready_before_accept", 32'(instr_ready), 1);
    instr_valid = 1'b1; instr = op;
    @(negedge clk);
    instr = 8'($urandom);
    resume = 1'($urandom);
    chk("decode_busy", 32'(busy), 1);
    chk("decode_ready", 32'(instr_ready), 0);
    @(negedge clk);
    chk("exec_no_strobe", 32'(destination_reg_flag), 0);
    chk("exec_no_req", 32'(mem_req), 0);
    if (early) mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; instr_valid = 1'b0; resume = 1'b0;
    case (e.kind)
      K_MOV: begin
        chk("mov_dest", 32'(destination_reg_flag), 32'(e.dflag));
        chk("mov_src", 32'(source_reg_sel), 32'(e.src));
        chk("mov_acc", 32'(acc_sel), 0);
        chk("mov_ill", 32'(illegal), 0);
        chk("mov_ready", 32'(instr_ready), 1);
        @(negedge clk);
        chk("mov_dest_1cyc", 32'(destination_reg_flag), 0);
      end
      K_ALU: begin
        chk("alu_dest", 32'(destination_reg_flag), 1);
        chk("alu_acc", 32'(acc_sel), 1);
        chk("alu_sel", 32'(alu_sel), 32'(e.alu));
        chk("alu_b", 32'(alu_b_sel), 32'(e.b));
        chk("alu_ill", 32'(illegal), 0);
        @(negedge clk);
        chk("alu_dest_1cyc", 32'(destination_reg_flag), 0);
        chk("alu_acc_1cyc", 32'(acc_sel), 0);
      end
      K_NOP, K_ILL: begin
        chk("nop_dest", 32'(destination_reg_flag), 0);
        chk("nop_req", 32'(mem_req), 0);
        chk("nop_ill", 32'(illegal), 32'(e.kind == K_ILL));
        chk("nop_ready", 32'(instr_ready), 1);
        @(negedge clk);
        chk("ill_1cyc", 32'(illegal), 0);
      end
      K_LOAD, K_STORE: begin
        chk("mem_req", 32'(mem_req), 1);
        chk("mem_write", 32'(write), 32'(e.kind == K_STORE));
        chk("mem_addr", 32'(address), 32'(e.addr));
        chk("mem_src", 32'(source_reg_sel), 0);
        chk("mem_ready", 32'(instr_ready), 0);
        for (int k = 1; k <= d; k++) begin
          if (k == d) mem_ack = 1'b1;
          @(negedge clk);
          mem_ack = 1'b0;
          if (k < d) begin
            chk("mem_req_held", 32'(mem_req), 1);
            chk("mem_addr_held", 32'(address), 32'(e.addr));
            chk("mem_write_held", 32'(write), 32'(e.kind == K_STORE));
          end else begin
            chk("mem_req_drop", 32'(mem_req), 0);
          end
        end
        chk("mem_no_early_wb", 32'(destination_reg_flag), 0);
        if (e.kind == K_LOAD) begin
          chk("load_wb_ready", 32'(instr_ready), 0);
          @(negedge clk);
          chk("load_wb", 32'(destination_reg_flag), 1);
          chk("load_done_ready", 32'(instr_ready), 1);
          chk("load_done_busy", 32'(busy), 0);
          @(negedge clk);
          chk("load_wb_1cyc", 32'(destination_reg_flag), 0);
        end else begin
          chk("store_ready", 32'(instr_ready), 1);
          chk("store_busy", 32'(busy), 0);
          @(negedge clk);
          chk("store_no_wb", 32'(destination_reg_flag), 0);
        end
      end
      default: begin
        chk("halt_halted", 32'(halted), 1);
        chk("halt_busy", 32'(busy), 0);
        instr_valid = 1'b1; instr = 8'h01;
        repeat (3) begin
          @(negedge clk);
          chk("halt_ready_low", 32'(instr_ready), 0);
          chk("halt_hold", 32'(halted), 1);
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0; instr_valid = 1'b0;
        chk("resume_halted", 32'(halted), 0);
        chk("resume_ready", 32'(instr_ready), 1);
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: run did not reach summary");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 0);
    chk("rst_dest", 32'(destination_reg_flag), 0);
    chk("rst_outs", 32'({mem_req, write, busy, halted, illegal, acc_sel}), 0);
    rst_n = 1'b1;
    chk("rel_ready_0", 32'(instr_ready), 0);
    @(negedge clk);
    chk("rel_ready_1", 32'(instr_ready), 1);

    do_instr(8'h01, 1, 1'b0);
    do_instr(8'h8A, 3, 1'b0);
    do_instr(8'hA5, 2, 1'b0);
    do_instr(8'h3C, 1, 1'b0);
    do_instr(8'hC3, 1, 1'b0);
    do_instr(8'hFF, 1, 1'b0);
    do_instr(8'h12, 1, 1'b0);
    do_instr(8'h09, 1, 1'b0);
    do_instr(8'h5A, 1, 1'b0);
    do_instr(8'h4F, 1, 1'b0);
    do_instr(8'hC0, 1, 1'b0);
    do_instr(8'h83, 2, 1'b1);

    // reset during MEM_WAIT, then a stale ack
    instr_valid = 1'b1; instr = 8'h87;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rmid_req", 32'(mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_req_async", 32'(mem_req), 0);
    chk("rmid_busy", 32'(busy), 0);
    mem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rmid_no_wb", 32'(destination_reg_flag), 0);
      chk("rmid_no_req", 32'(mem_req), 0);
    end
    mem_ack = 1'b0;
    chk("rmid_ready", 32'(instr_ready), 1);

    for (int i = 0; i < 80; i++)
      do_instr(8'($urandom_range(0, 255)), int'($urandom_range(1, 4)), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
